// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: decodes load-use,
// ID-stage branch-operand and multi-cycle memory hazards into register
// enables, flushes and bubbles, with a memory wait-state FSM and stall counter.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       rs1ID,
    input  logic [2:0]       rs2ID,
    input  logic             useRs1ID,
    input  logic             useRs2ID,
    input  logic             isBranchID,
    input  logic             branchTakenID,
    input  logic [2:0]       rdEX,
    input  logic             regWriteEX,
    input  logic             memReadEX,
    input  logic             memReqMEM,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             exmemWrite,
    output logic             memwbWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             memwbBubble,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic m1, m2, load_use, br_haz, front_haz, mem_stall;
    logic freeze, front, flush;

    // Hazard terms; register 0 is deliberately not exempt from matching.
    always_comb begin
        m1        = useRs1ID & (rs1ID == rdEX);
        m2        = useRs2ID & (rs2ID == rdEX);
        load_use  = memReadEX & (m1 | m2);
        br_haz    = isBranchID & regWriteEX & (m1 | m2);
        front_haz = load_use | br_haz;
        mem_stall = memReqMEM & ~memReady;
    end

    // Wait-state FSM next state plus stall classification for this cycle.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        freeze    = 1'b0;
        front     = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    wait_d  = CntOne;
                end else if (front_haz) begin
                    front = 1'b1;
                end else begin
                    flush = branchTakenID;
                end
            end
            StMemWait: begin
                if (memReady) begin
                    state_d = StRun;
                    wait_d  = '0;
                    if (front_haz) front = 1'b1;
                    else           flush = branchTakenID;
                end else begin
                    freeze = 1'b1;
                    wait_d = wait_q + CntOne;
                    if (wait_q == TimeoutVal) begin
                        state_d   = StError;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                // Error is terminal until reset; inputs are ignored.
                freeze    = 1'b1;
                timeout_d = 1'b1;
            end
        endcase
    end

    // Output decode; reset forces every control low.
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        exmemWrite  = 1'b1;
        memwbWrite  = 1'b1;
        ifidFlush   = flush;
        idexBubble  = 1'b0;
        memwbBubble = 1'b0;
        if (freeze) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            memwbWrite  = 1'b0;
            ifidFlush   = 1'b0;
            memwbBubble = 1'b1;
        end else if (front) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b0;
            idexBubble = 1'b1;
        end
        if (!reset_n) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            memwbWrite  = 1'b0;
            ifidFlush   = 1'b0;
            idexBubble  = 1'b0;
            memwbBubble = 1'b0;
        end
    end

    // Saturating count of cycles with any stall or freeze active.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((freeze | front) && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CntOne;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign memTimeout = timeout_q;
    assign stallCount = stall_cnt_q;

endmodule
